// File: rtl/muldiv_engine.sv
// Iterative signed multiply/divide engine: one bit per RUN cycle, tag passthrough, kill, exceptions.
// Latency: WIDTH+1 edges from accept to the fall of result_rdy (1 edge for a divide-by-zero when MULDIV_FAST_DIV0_EN is defined).
// Backpressure: busy holds issue while running; starts seen in RUN, or with kill or both starts high, are dropped.
module muldiv_engine #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mul,
    input  logic             start_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             kill,
    output logic             busy,
    output logic             result_rdy,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic [TAG_W-1:0] tag_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               div0_q, div0_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic [TAG_W-1:0]   tag_out_q, tag_out_d;

    logic               a_neg, b_neg, b_zero, ovf_in, accept;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, step_acc, prod_s;
    logic               mul_exc;
    logic [WIDTH-1:0]   quo_s, fin_res;
    logic               fin_exc;

    assign a_neg  = operand_a[WIDTH-1];
    assign b_neg  = operand_b[WIDTH-1];
    // MIN negates to itself, which is exactly 2^(WIDTH-1) read as unsigned.
    assign a_mag  = a_neg ? -operand_a : operand_a;
    assign b_mag  = b_neg ? -operand_b : operand_b;
    assign b_zero = (operand_b == '0);
    assign ovf_in = (operand_a == MIN_VAL) && (&operand_b);
    assign accept = (start_mul ^ start_div) && !kill && (state_q != RUN);

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each cycle.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left each cycle.
    // The remainder stays below the divisor, so div_shift never reaches bit WIDTH and
    // the top bit of div_diff is a clean borrow.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_q};
    assign div_ge    = !div_diff[WIDTH];
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};

    assign step_acc = is_div_q ? div_next : mul_next;

    assign prod_s  = neg_q ? -step_acc : step_acc;
    assign mul_exc = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
    assign quo_s   = neg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];

    always_comb begin
        fin_res = prod_s[WIDTH-1:0];
        fin_exc = mul_exc;
        if (is_div_q) begin
            if (div0_q) begin
                fin_res = '0;
                fin_exc = 1'b1;
            end else begin
                fin_res = quo_s;
                fin_exc = ovf_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        mag_d     = mag_q;
        acc_d     = acc_q;
        tag_d     = tag_q;
        result_d  = result_q;
        exc_d     = exc_q;
        tag_out_d = tag_out_q;
        case (state_q)
            RUN: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d   = DONE;
                        result_d  = fin_res;
                        exc_d     = fin_exc;
                        tag_out_d = tag_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    is_div_d = start_div;
                    neg_d    = a_neg ^ b_neg;
                    div0_d   = b_zero;
                    ovf_d    = ovf_in;
                    tag_d    = tag_in;
                    mag_d    = start_div ? b_mag : a_mag;
                    acc_d    = {{WIDTH{1'b0}}, (start_div ? a_mag : b_mag)};
`ifdef MULDIV_FAST_DIV0_EN
                    if (start_div && b_zero) begin
                        state_d   = DONE;
                        result_d  = '0;
                        exc_d     = 1'b1;
                        tag_out_d = tag_in;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            mag_q     <= '0;
            acc_q     <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            mag_q     <= mag_d;
            acc_q     <= acc_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            tag_out_q <= tag_out_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign result_rdy = (state_q == DONE);
    assign result     = result_q;
    assign exception  = exc_q;
    assign tag_out    = tag_out_q;

endmodule

// File: tb/tb_muldiv_engine.sv
// Directed + random bench for muldiv_engine with a result scoreboard.
module tb_muldiv_engine;
    localparam int W  = 32;
    localparam int TW = 5;

    typedef struct packed {
        logic [W-1:0]  res;
        logic          exc;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start_mul = 1'b0;
    logic          start_div = 1'b0;
    logic [W-1:0]  operand_a = '0;
    logic [W-1:0]  operand_b = '0;
    logic [TW-1:0] tag_in = '0;
    logic          kill = 1'b0;
    logic          busy, result_rdy, exception;
    logic [W-1:0]  result;
    logic [TW-1:0] tag_out;

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t last_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    muldiv_engine #(.WIDTH(W), .TAG_W(TW)) dut (
        .clock(clock), .reset(reset), .start_mul(start_mul), .start_div(start_div),
        .operand_a(operand_a), .operand_b(operand_b), .tag_in(tag_in), .kill(kill),
        .busy(busy), .result_rdy(result_rdy), .result(result), .exception(exception),
        .tag_out(tag_out)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic mul, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [TW-1:0] tag);
        exp_t e;
        longint sa, sb, p;
        logic signed [W-1:0] r;
        sa = $signed(a);
        sb = $signed(b);
        e.tag = tag;
        if (mul) begin
            p = sa * sb;
            r = p[W-1:0];
            e.res = r;
            e.exc = (p != longint'(r));
        end else if (b == '0) begin
            e.res = '0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = a;
            e.exc = 1'b1;
        end else begin
            p = sa / sb;
            e.res = p[W-1:0];
            e.exc = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clock) begin
        #1;
        if (result_rdy === 1'b1) begin
            n_tests++;
            assert (sb_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_rdy: observed pulse with %0d pending, expected >0", sb_q.size());
            end
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("result", result, mon_e.res);
                check("exception", exception, mon_e.exc);
                check("tag_out", tag_out, mon_e.tag);
            end
        end
    end

    task automatic issue(input logic mul, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag, input bit push);
        start_mul = mul;
        start_div = !mul;
        operand_a = a;
        operand_b = b;
        tag_in    = tag;
        if (push) begin
            last_exp = model(mul, a, b, tag);
            sb_q.push_back(last_exp);
        end
        @(posedge clock); #1;
        start_mul = 1'b0;
        start_div = 1'b0;
    endtask

    // Edges from accept to the fall of result_rdy, and cycles busy was seen high.
    task automatic wait_rdy(output int lat, output int busy_n);
        int n = 0;
        busy_n = 0;
        while (result_rdy !== 1'b1 && n < 100) begin
            if (busy === 1'b1) busy_n++;
            @(posedge clock); #1;
            n++;
        end
        lat = n + 1;
    endtask

    task automatic run_op(input logic mul, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag, output int lat, output int busy_n);
        issue(mul, a, b, tag, 1'b1);
        wait_rdy(lat, busy_n);
    endtask

    task automatic idle_window(input int cycles, output int busy_n, output int rdy_n);
        busy_n = 0;
        rdy_n  = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            if (busy !== 1'b0) busy_n++;
            if (result_rdy !== 1'b0) rdy_n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bn, rn;
        logic [W-1:0] ra, rb;
        exp_t held;

        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_rdy", result_rdy, 0);
        check("rst_result", result, 0);
        check("rst_exc", exception, 0);
        check("rst_tag", tag_out, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        run_op(1'b1, 32'd7, 32'hFFFF_FFFD, 5'd9, lat, bn);
        check("mul_lat", lat, W + 1);
        check("mul_busy_cycles", bn, W);
        @(posedge clock); #1;
        check("rdy_one_cycle", result_rdy, 0);
        check("result_hold", result, 32'hFFFF_FFEB);

        run_op(1'b1, 32'h0001_0000, 32'h0001_0000, 5'd3, lat, bn);
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 5'd4, lat, bn);
        check("div_lat", lat, W + 1);

        run_op(1'b0, 32'd5, 32'd0, 5'd5, lat, bn);
`ifdef MULDIV_FAST_DIV0_EN
        check("div0_lat", lat, 1);
        check("div0_busy", bn, 0);
`else
        check("div0_lat", lat, W + 1);
        check("div0_busy", bn, W);
`endif

        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, lat, bn);
        check("b2b_gap_busy", busy, 0);
        run_op(1'b0, 32'd100, 32'hFFFF_FFF9, 5'd7, lat, bn);
        check("b2b_lat", lat, W + 1);
        check("b2b_busy_cycles", bn, W);

        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, lat, bn);
        run_op(1'b1, 32'h8000_0000, 32'd1, 5'd10, lat, bn);
        run_op(1'b0, 32'h8000_0000, 32'd1, 5'd11, lat, bn);
        run_op(1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd12, lat, bn);
        run_op(1'b0, 32'd7, 32'hFFFF_FF9C, 5'd13, lat, bn);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rb = -rb;
            run_op($urandom_range(0, 1) == 1, ra, rb, 5'(i + 16), lat, bn);
        end

        // Kill in RUN cycle 10: no result, outputs keep the last completed op.
        held = last_exp;
        issue(1'b1, 32'd3, 32'd4, 5'd1, 1'b0);
        repeat (10) begin @(posedge clock); #1; end
        kill = 1'b1;
        @(posedge clock); #1;
        kill = 1'b0;
        check("kill_busy", busy, 0);
        check("kill_rdy", result_rdy, 0);
        check("kill_result_hold", result, held.res);
        check("kill_exc_hold", exception, held.exc);
        check("kill_tag_hold", tag_out, held.tag);
        idle_window(40, bn, rn);
        check("kill_no_rdy", rn, 0);

        start_mul = 1'b1;
        start_div = 1'b1;
        @(posedge clock); #1;
        start_mul = 1'b0;
        start_div = 1'b0;
        check("both_starts_busy", busy, 0);
        start_mul = 1'b1;
        kill      = 1'b1;
        @(posedge clock); #1;
        start_mul = 1'b0;
        kill      = 1'b0;
        check("kill_start_busy", busy, 0);
        idle_window(40, bn, rn);
        check("rejected_busy", bn, 0);
        check("rejected_rdy", rn, 0);

        // Asynchronous reset at RUN cycle 20, applied between clock edges.
        issue(1'b1, 32'd5, 32'd6, 5'd2, 1'b0);
        repeat (20) begin @(posedge clock); #1; end
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rdy", result_rdy, 0);
        check("arst_result", result, 0);
        check("arst_exc", exception, 0);
        check("arst_tag", tag_out, 0);
        #1;
        reset = 1'b1;
        idle_window(40, bn, rn);
        check("post_rst_busy", bn, 0);
        check("post_rst_rdy", rn, 0);
        run_op(1'b1, 32'hFFFF_FFFB, 32'd6, 5'd14, lat, bn);
        check("post_rst_lat", lat, W + 1);
        @(posedge clock); #1;

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
